// File: rtl/prog_loader.sv
// prog_loader: streams a little-endian byte program into instruction memory while
// holding the core in reset, then runs it through a start/done handshake with a timeout.
module prog_loader #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [ADDR_W:0]   load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              cpu_start,
    input  logic              cpu_done,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_RELEASE,
        S_WAIT,
        S_FINISH
    } state_t;

    localparam logic [ADDR_W:0] MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_W     = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [15:0]     TIMEOUT_C = 16'(TIMEOUT);

    state_t              state_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W:0]     word_idx_q;
    logic [ADDR_W:0]     word_idx_d;
    logic [1:0]          byte_idx_q;
    logic [23:0]         word_q;
    logic [15:0]         cycle_count_q;
    logic [15:0]         cycle_count_d;
    logic                byte_ready_q;
    logic                imem_we_q;
    logic [ADDR_W-1:0]   imem_addr_q;
    logic [31:0]         imem_wdata_q;
    logic                cpu_rst_q;
    logic                cpu_start_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    assign word_idx_d    = word_idx_q + ONE_W;
    assign cycle_count_d = cycle_count_q + 16'd1;

    // Byte handshake: a byte transfers on every rising edge where byte_valid && byte_ready;
    // the source keeps byte_data stable while byte_valid is high and not yet accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            word_idx_q    <= '0;
            byte_idx_q    <= '0;
            word_q        <= '0;
            cycle_count_q <= '0;
            byte_ready_q  <= 1'b0;
            imem_we_q     <= 1'b0;
            imem_addr_q   <= '0;
            imem_wdata_q  <= '0;
            cpu_rst_q     <= 1'b1;
            cpu_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_FINISH: begin
                    if (go) begin
                        done_q        <= 1'b0;
                        err_q         <= 1'b0;
                        cycle_count_q <= '0;
                        word_idx_q    <= '0;
                        byte_idx_q    <= '0;
                        len_q         <= load_len;
                        cpu_rst_q     <= 1'b1;
                        cpu_start_q   <= 1'b0;
                        if (load_len > MAX_LEN) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (load_len == '0) begin
                            state_q   <= S_RELEASE;
                            busy_q    <= 1'b1;
                            cpu_rst_q <= 1'b0;
                        end else begin
                            state_q      <= S_LOAD;
                            busy_q       <= 1'b1;
                            byte_ready_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (byte_valid && byte_ready_q) begin
                        if (byte_idx_q == 2'd3) begin
                            // The 4th byte goes straight into the write data, not the word register.
                            state_q      <= S_WRITE;
                            byte_ready_q <= 1'b0;
                            imem_we_q    <= 1'b1;
                            imem_addr_q  <= word_idx_q[ADDR_W-1:0];
                            imem_wdata_q <= {byte_data, word_q};
                            byte_idx_q   <= 2'd0;
                        end else begin
                            case (byte_idx_q)
                                2'd0:    word_q[7:0]   <= byte_data;
                                2'd1:    word_q[15:8]  <= byte_data;
                                default: word_q[23:16] <= byte_data;
                            endcase
                            byte_idx_q <= byte_idx_q + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    word_idx_q <= word_idx_d;
                    if (word_idx_d == len_q) begin
                        state_q   <= S_RELEASE;
                        cpu_rst_q <= 1'b0;
                    end else begin
                        state_q      <= S_LOAD;
                        byte_ready_q <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    state_q     <= S_WAIT;
                    cpu_start_q <= 1'b1;
                end
                S_WAIT: begin
                    if (cpu_done) begin
                        state_q     <= S_FINISH;
                        done_q      <= 1'b1;
                        err_q       <= 1'b0;
                        busy_q      <= 1'b0;
                        cpu_start_q <= 1'b0;
                    end else begin
                        cycle_count_q <= cycle_count_d;
                        if (cycle_count_d == TIMEOUT_C) begin
                            state_q     <= S_FINISH;
                            done_q      <= 1'b1;
                            err_q       <= 1'b1;
                            busy_q      <= 1'b0;
                            cpu_start_q <= 1'b0;
                            cpu_rst_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign byte_ready  = byte_ready_q;
    assign imem_we     = imem_we_q;
    assign imem_addr   = imem_addr_q;
    assign imem_wdata  = imem_wdata_q;
    assign cpu_rst     = cpu_rst_q;
    assign cpu_start   = cpu_start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader (ADDR_W=4, TIMEOUT=8): table of whole load+run scenarios
// plus hand-written sequences for handshake timing, mid-load reset and bad length.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic [4:0]  load_len = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        cpu_start;
  logic        cpu_done = 1'b0;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] cycle_count;

  int checks = 0;
  int failures = 0;

  prog_loader #(.ADDR_W(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .go(go), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .cpu_start(cpu_start), .cpu_done(cpu_done),
    .busy(busy), .done(done), .err(err), .cycle_count(cycle_count)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // imem model / monitor
  logic [31:0] mem [16];
  int we_count = 0;
  int overlap = 0;
  bit start_seen = 1'b0;

  always @(negedge clk) begin
    if (imem_we) begin
      mem[imem_addr] = imem_wdata;
      we_count++;
      if (byte_ready) overlap++;
    end
    if (cpu_start) start_seen = 1'b1;
  end

  typedef struct {
    logic [4:0]  len;
    logic [63:0] data;
    bit          gappy;
    int          done_at;
    logic [15:0] exp_count;
    logic        exp_err;
    logic        exp_rst;
    int          exp_we;
    logic [31:0] exp_w0;
    logic [31:0] exp_wl;
    bit          exp_started;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) mem[i] = '0;
    we_count = 0;
    start_seen = 1'b0;
  endtask

  function automatic logic [7:0] byte_at(input logic [63:0] d, input int k);
    if (k < 8) return d[8*k +: 8];
    return 8'((k * 7 + 3) % 256);
  endfunction

  // driver tasks (called just after a falling edge)
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      failures++;
      $display("FAIL byte_accept_timeout actual=ready_low expected=ready_high");
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_go(input logic [4:0] len);
    load_len = len;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_finish(input int done_at, output bit ok);
    int starts = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (cpu_start) starts++;
      cpu_done = (done_at != 0) && (starts == done_at);
      @(negedge clk);
    end
    cpu_done = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit ok;
    clear_model();
    pulse_go(v.len);
    if (v.len <= 5'd16) begin
      for (int k = 0; k < 4 * int'(v.len); k++) begin
        if (v.gappy && (k % 2 == 1)) begin
          byte_valid = 1'b0;
          repeat (2) @(negedge clk);
        end
        send_byte(byte_at(v.data, k));
      end
    end
    wait_finish(v.done_at, ok);
    check($sformatf("v%0d_finish_reached", idx), 32'(ok), 32'd1);
    check($sformatf("v%0d_done", idx), 32'(done), 32'd1);
    check($sformatf("v%0d_err", idx), 32'(err), 32'(v.exp_err));
    check($sformatf("v%0d_cycle_count", idx), 32'(cycle_count), 32'(v.exp_count));
    check($sformatf("v%0d_cpu_rst", idx), 32'(cpu_rst), 32'(v.exp_rst));
    check($sformatf("v%0d_cpu_start", idx), 32'(cpu_start), 32'd0);
    check($sformatf("v%0d_busy", idx), 32'(busy), 32'd0);
    check($sformatf("v%0d_we_pulses", idx), 32'(we_count), 32'(v.exp_we));
    check($sformatf("v%0d_start_seen", idx), 32'(start_seen), 32'(v.exp_started));
    if (v.exp_we > 0) begin
      check($sformatf("v%0d_mem_first", idx), mem[0], v.exp_w0);
      check($sformatf("v%0d_mem_last", idx), mem[int'(v.len) - 1], v.exp_wl);
      check($sformatf("v%0d_addr_hold", idx), 32'(imem_addr), 32'(int'(v.len) - 1));
      check($sformatf("v%0d_wdata_hold", idx), imem_wdata, v.exp_wl);
    end
  endtask

  initial begin
    bit ok;

    vecs[0] = '{len:5'd2, data:64'hDEADBEEF_12345678, gappy:1'b0, done_at:3, exp_count:16'd2,
                exp_err:1'b0, exp_rst:1'b0, exp_we:2, exp_w0:32'h12345678, exp_wl:32'hDEADBEEF, exp_started:1'b1};
    vecs[1] = '{len:5'd2, data:64'hDEADBEEF_12345678, gappy:1'b1, done_at:3, exp_count:16'd2,
                exp_err:1'b0, exp_rst:1'b0, exp_we:2, exp_w0:32'h12345678, exp_wl:32'hDEADBEEF, exp_started:1'b1};
    vecs[2] = '{len:5'd0, data:64'h0, gappy:1'b0, done_at:1, exp_count:16'd0,
                exp_err:1'b0, exp_rst:1'b0, exp_we:0, exp_w0:32'h0, exp_wl:32'h0, exp_started:1'b1};
    // done arriving on the edge that would otherwise time out
    vecs[3] = '{len:5'd0, data:64'h0, gappy:1'b0, done_at:8, exp_count:16'd7,
                exp_err:1'b0, exp_rst:1'b0, exp_we:0, exp_w0:32'h0, exp_wl:32'h0, exp_started:1'b1};
    vecs[4] = '{len:5'd17, data:64'h0, gappy:1'b0, done_at:0, exp_count:16'd0,
                exp_err:1'b1, exp_rst:1'b1, exp_we:0, exp_w0:32'h0, exp_wl:32'h0, exp_started:1'b0};
    vecs[5] = '{len:5'd1, data:64'h0000_0000_CAFEF00D, gappy:1'b0, done_at:0, exp_count:16'd8,
                exp_err:1'b1, exp_rst:1'b1, exp_we:1, exp_w0:32'hCAFEF00D, exp_wl:32'hCAFEF00D, exp_started:1'b1};
    vecs[6] = '{len:5'd16, data:64'h07060504_03020100, gappy:1'b0, done_at:1, exp_count:16'd0,
                exp_err:1'b0, exp_rst:1'b0, exp_we:16, exp_w0:32'h03020100, exp_wl:32'hBCB5AEA7, exp_started:1'b1};

    // reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_cpu_start", 32'(cpu_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cycle_count", 32'(cycle_count), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // zero-length run: reset release and start request timing
    clear_model();
    pulse_go(5'd0);
    check("len0_cpu_rst_drop", 32'(cpu_rst), 32'd0);
    check("len0_start_low", 32'(cpu_start), 32'd0);
    check("len0_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("len0_start_rise", 32'(cpu_start), 32'd1);
    check("len0_rst_still_low", 32'(cpu_rst), 32'd0);
    wait_finish(1, ok);
    check("len0_finish", 32'(ok), 32'd1);
    check("len0_no_writes", 32'(we_count), 32'd0);

    // bad length finishes on the edge that accepts go
    clear_model();
    pulse_go(5'd17);
    check("bad_done_now", 32'(done), 32'd1);
    check("bad_err_now", 32'(err), 32'd1);
    check("bad_busy", 32'(busy), 32'd0);
    check("bad_cpu_rst", 32'(cpu_rst), 32'd1);

    // reset in the middle of word 0, then a clean reload with an ignored go
    clear_model();
    pulse_go(5'd1);
    check("load_busy", 32'(busy), 32'd1);
    check("load_byte_ready", 32'(byte_ready), 32'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_byte_ready", 32'(byte_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("midrst_imem_addr", 32'(imem_addr), 32'd0);
    check("midrst_imem_wdata", imem_wdata, 32'd0);
    @(negedge clk);
    check("midrst_no_write", 32'(we_count), 32'd0);
    pulse_go(5'd1);
    send_byte(8'h01);
    pulse_go(5'd2);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    wait_finish(1, ok);
    check("reload_finish", 32'(ok), 32'd1);
    check("reload_mem0", mem[0], 32'h04030201);
    check("reload_we_pulses", 32'(we_count), 32'd1);
    check("reload_err", 32'(err), 32'd0);

    check("we_ready_overlap", 32'(overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
